// File: rtl/cpu_pkg.sv
// Shared LEGv8 pipeline types used by the hazard sequencer: the zero register index,
// the stall FSM state encoding and the remaining-stall counter type.
package cpu_pkg;

    localparam logic [4:0] XZR = 5'd31;

    typedef enum logic {HZ_RUN, HZ_STALL} hz_state_t;

    typedef logic [1:0] stall_cnt_t;

endpackage

// File: rtl/hazard_need.sv
// Combinational stall-need calculation: how many bubbles the ID instruction needs
// (0, 1 or 2) given the producers currently sitting in EX and MEM.
module hazard_need
    import cpu_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] if_id_rn,
    input  logic [REG_W-1:0] if_id_rm,
    input  logic             if_id_uses_rm,
    input  logic             if_id_is_cbz,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             id_ex_reg_write,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] ex_mem_rd,
    input  logic             ex_mem_mem_read,
    output logic [1:0]       need
);

    logic ex_rd_live;
    logic mem_rd_live;
    logic load_use;
    logic cbz_vs_ex;
    logic cbz_vs_mem;

    // XZR reads as zero and discards writes, so it can never carry a dependency.
    assign ex_rd_live  = (id_ex_rd  != REG_W'(XZR));
    assign mem_rd_live = (ex_mem_rd != REG_W'(XZR));

    assign load_use   = id_ex_mem_read & ex_rd_live &
                        ((id_ex_rd == if_id_rn) | (if_id_uses_rm & (id_ex_rd == if_id_rm)));
    assign cbz_vs_ex  = if_id_is_cbz & id_ex_reg_write & ex_rd_live & (id_ex_rd == if_id_rm);
    assign cbz_vs_mem = if_id_is_cbz & ex_mem_mem_read & mem_rd_live & (ex_mem_rd == if_id_rm);

    always_comb begin
        need = 2'd0;
        if (load_use || cbz_vs_ex || cbz_vs_mem) begin
            need = 2'd1;
        end
        // A CBZ behind a load must wait for the loaded value to leave MEM.
        if (cbz_vs_ex && id_ex_mem_read) begin
            need = 2'd2;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage LEGv8 pipeline (RUN/STALL FSM plus output decode).
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dmem_busy,
    input  logic [REG_W-1:0] if_id_rn,
    input  logic [REG_W-1:0] if_id_rm,
    input  logic             if_id_uses_rm,
    input  logic             if_id_is_cbz,
    input  logic             br_taken,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             id_ex_reg_write,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] ex_mem_rd,
    input  logic             ex_mem_mem_read,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             stall_active
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    hz_state_t  state, state_n;
    stall_cnt_t cnt, cnt_n;
    logic [1:0] need;

    hazard_need #(.REG_W(REG_W)) u_need (
        .if_id_rn        (if_id_rn),
        .if_id_rm        (if_id_rm),
        .if_id_uses_rm   (if_id_uses_rm),
        .if_id_is_cbz    (if_id_is_cbz),
        .id_ex_rd        (id_ex_rd),
        .id_ex_reg_write (id_ex_reg_write),
        .id_ex_mem_read  (id_ex_mem_read),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_mem_read (ex_mem_mem_read),
        .need            (need)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= HZ_RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        if_id_flush  = 1'b0;
        if (!reset) begin
            // Held in reset: enables off, bubble injected, defaults already describe this.
        end else if (dmem_busy) begin
            // Whole pipe frozen; nothing may be clocked into ID/EX, not even a bubble.
            id_ex_bubble = 1'b0;
        end else if (state == HZ_STALL) begin
            cnt_n = cnt - 2'd1;
            if (cnt <= 2'd1) begin
                state_n = HZ_RUN;
            end
        end else if (need != 2'd0) begin
            if (need == 2'd2) begin
                state_n = HZ_STALL;
                cnt_n   = 2'd1;
            end
        end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_bubble = 1'b0;
            if_id_flush  = br_taken;
        end
    end

    assign stall_active = (state == HZ_STALL);

`ifdef HAZARD_PERF_EN
    // Saturating counters; a frozen (dmem_busy) cycle drives neither bubble nor flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (id_ex_bubble && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (if_id_flush && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; outputs are packed as
// {pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_active} and compared per cycle.
module tb_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 32;

    localparam logic [4:0] O_RUN = 5'b11000;  // normal advance
    localparam logic [4:0] O_STL = 5'b00100;  // stall cycle from RUN
    localparam logic [4:0] O_STA = 5'b00101;  // stall cycle inside STALL
    localparam logic [4:0] O_FLU = 5'b11010;  // advance with IF/ID flush
    localparam logic [4:0] O_BST = 5'b00001;  // frozen by dmem_busy while in STALL
    localparam logic [4:0] O_BSY = 5'b00000;  // frozen by dmem_busy while in RUN
    localparam logic [4:0] O_RST = 5'b00100;  // reset held

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             dmem_busy;
    logic [REG_W-1:0] if_id_rn, if_id_rm, id_ex_rd, ex_mem_rd;
    logic             if_id_uses_rm, if_id_is_cbz, br_taken;
    logic             id_ex_reg_write, id_ex_mem_read, ex_mem_mem_read;
    logic             pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_active;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cycles, flush_count;
`endif

    int tests = 0;
    int fails = 0;

    wire [4:0] outs = {pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_active};

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .dmem_busy       (dmem_busy),
        .if_id_rn        (if_id_rn),
        .if_id_rm        (if_id_rm),
        .if_id_uses_rm   (if_id_uses_rm),
        .if_id_is_cbz    (if_id_is_cbz),
        .br_taken        (br_taken),
        .id_ex_rd        (id_ex_rd),
        .id_ex_reg_write (id_ex_reg_write),
        .id_ex_mem_read  (id_ex_mem_read),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_mem_read (ex_mem_mem_read),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_flush     (if_id_flush),
        .stall_active    (stall_active)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    task automatic drive_idle();
        dmem_busy       = 1'b0;
        if_id_rn        = 5'd1;
        if_id_rm        = 5'd1;
        if_id_uses_rm   = 1'b0;
        if_id_is_cbz    = 1'b0;
        br_taken        = 1'b0;
        id_ex_rd        = 5'd0;
        id_ex_reg_write = 1'b0;
        id_ex_mem_read  = 1'b0;
        ex_mem_rd       = 5'd0;
        ex_mem_mem_read = 1'b0;
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        id_ex_rd = 5'd1; id_ex_mem_read = 1'b1; br_taken = 1'b1;
        @(negedge clk); tests++;
        if (outs !== O_RST) begin fails++; $display("FAIL reset_outputs: got %b want %b", outs, O_RST); end
        next_cycle();
        reset = 1'b1;
        @(negedge clk); tests++;
        if (outs !== O_RUN) begin fails++; $display("FAIL reset_release_run: got %b want %b", outs, O_RUN); end
    endtask

    task automatic test_load_use();
        next_cycle();
        id_ex_rd = 5'd2; id_ex_reg_write = 1'b1; id_ex_mem_read = 1'b1; if_id_rn = 5'd2;
        @(negedge clk); tests++;
        if (outs !== O_STL) begin fails++; $display("FAIL load_use_rn_stall: got %b want %b", outs, O_STL); end
        next_cycle();
        ex_mem_rd = 5'd2; ex_mem_mem_read = 1'b1; if_id_rn = 5'd2;
        @(negedge clk); tests++;
        if (outs !== O_RUN) begin fails++; $display("FAIL load_use_rn_resume: got %b want %b", outs, O_RUN); end
        next_cycle();
        id_ex_rd = 5'd7; id_ex_mem_read = 1'b1; if_id_rn = 5'd5; if_id_rm = 5'd7; if_id_uses_rm = 1'b1;
        @(negedge clk); tests++;
        if (outs !== O_STL) begin fails++; $display("FAIL load_use_rm_stall: got %b want %b", outs, O_STL); end
        next_cycle();
        id_ex_rd = 5'd7; id_ex_mem_read = 1'b1; if_id_rn = 5'd5; if_id_rm = 5'd7; if_id_uses_rm = 1'b0;
        @(negedge clk); tests++;
        if (outs !== O_RUN) begin fails++; $display("FAIL load_use_rm_unused: got %b want %b", outs, O_RUN); end
        next_cycle();
        id_ex_rd = 5'd31; id_ex_mem_read = 1'b1; if_id_rn = 5'd31;
        @(negedge clk); tests++;
        if (outs !== O_RUN) begin fails++; $display("FAIL load_use_xzr: got %b want %b", outs, O_RUN); end
    endtask

    task automatic test_cbz_after_load();
        next_cycle();
        id_ex_rd = 5'd3; id_ex_reg_write = 1'b1; id_ex_mem_read = 1'b1;
        if_id_is_cbz = 1'b1; if_id_uses_rm = 1'b1; if_id_rm = 5'd3;
        @(negedge clk); tests++;
        if (outs !== O_STL) begin fails++; $display("FAIL cbz_load_cycle1: got %b want %b", outs, O_STL); end
        next_cycle();
        ex_mem_rd = 5'd3; ex_mem_mem_read = 1'b1; if_id_is_cbz = 1'b1; if_id_uses_rm = 1'b1;
        if_id_rm = 5'd3; br_taken = 1'b1;
        @(negedge clk); tests++;
        if (outs !== O_STA) begin fails++; $display("FAIL cbz_load_cycle2: got %b want %b", outs, O_STA); end
        next_cycle();
        if_id_is_cbz = 1'b1; if_id_uses_rm = 1'b1; if_id_rm = 5'd3;
        @(negedge clk); tests++;
        if (outs !== O_RUN) begin fails++; $display("FAIL cbz_load_resume: got %b want %b", outs, O_RUN); end
    endtask

    task automatic test_cbz_after_alu();
        next_cycle();
        id_ex_rd = 5'd4; id_ex_reg_write = 1'b1; if_id_is_cbz = 1'b1; if_id_uses_rm = 1'b1; if_id_rm = 5'd4;
        @(negedge clk); tests++;
        if (outs !== O_STL) begin fails++; $display("FAIL cbz_alu_stall: got %b want %b", outs, O_STL); end
        next_cycle();
        ex_mem_rd = 5'd4; if_id_is_cbz = 1'b1; if_id_uses_rm = 1'b1; if_id_rm = 5'd4;
        @(negedge clk); tests++;
        if (outs !== O_RUN) begin fails++; $display("FAIL cbz_alu_resume: got %b want %b", outs, O_RUN); end
        next_cycle();
        id_ex_rd = 5'd31; id_ex_reg_write = 1'b1; if_id_is_cbz = 1'b1; if_id_uses_rm = 1'b1; if_id_rm = 5'd31;
        @(negedge clk); tests++;
        if (outs !== O_RUN) begin fails++; $display("FAIL cbz_alu_xzr: got %b want %b", outs, O_RUN); end
        next_cycle();
        ex_mem_rd = 5'd6; ex_mem_mem_read = 1'b1; if_id_is_cbz = 1'b1; if_id_uses_rm = 1'b1; if_id_rm = 5'd6;
        @(negedge clk); tests++;
        if (outs !== O_STL) begin fails++; $display("FAIL cbz_vs_mem_stall: got %b want %b", outs, O_STL); end
    endtask

    task automatic test_flush();
        next_cycle();
        br_taken = 1'b1;
        @(negedge clk); tests++;
        if (outs !== O_FLU) begin fails++; $display("FAIL branch_flush: got %b want %b", outs, O_FLU); end
        next_cycle();
        @(negedge clk); tests++;
        if (outs !== O_RUN) begin fails++; $display("FAIL branch_flush_one_cycle: got %b want %b", outs, O_RUN); end
        next_cycle();
        br_taken = 1'b1; id_ex_rd = 5'd9; id_ex_mem_read = 1'b1; if_id_rn = 5'd9;
        @(negedge clk); tests++;
        if (outs !== O_STL) begin fails++; $display("FAIL branch_in_stall: got %b want %b", outs, O_STL); end
    endtask

    task automatic test_dmem_busy();
        next_cycle();
        dmem_busy = 1'b1; id_ex_rd = 5'd8; id_ex_mem_read = 1'b1; if_id_rn = 5'd8; br_taken = 1'b1;
        @(negedge clk); tests++;
        if (outs !== O_BSY) begin fails++; $display("FAIL busy_in_run: got %b want %b", outs, O_BSY); end
        next_cycle();
        id_ex_rd = 5'd3; id_ex_reg_write = 1'b1; id_ex_mem_read = 1'b1;
        if_id_is_cbz = 1'b1; if_id_uses_rm = 1'b1; if_id_rm = 5'd3;
        @(negedge clk); tests++;
        if (outs !== O_STL) begin fails++; $display("FAIL busy_enter_stall: got %b want %b", outs, O_STL); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            dmem_busy = 1'b1; br_taken = 1'b1;
            @(negedge clk); tests++;
            if (outs !== O_BST) begin fails++; $display("FAIL busy_hold_%0d: got %b want %b", i, outs, O_BST); end
        end
        next_cycle();
        @(negedge clk); tests++;
        if (outs !== O_STA) begin fails++; $display("FAIL busy_release_stall: got %b want %b", outs, O_STA); end
        next_cycle();
        @(negedge clk); tests++;
        if (outs !== O_RUN) begin fails++; $display("FAIL busy_back_to_run: got %b want %b", outs, O_RUN); end
    endtask

    task automatic test_reset_mid_stall();
        next_cycle();
        id_ex_rd = 5'd3; id_ex_reg_write = 1'b1; id_ex_mem_read = 1'b1;
        if_id_is_cbz = 1'b1; if_id_uses_rm = 1'b1; if_id_rm = 5'd3;
        @(negedge clk); tests++;
        if (outs !== O_STL) begin fails++; $display("FAIL mid_stall_enter: got %b want %b", outs, O_STL); end
        next_cycle();
        reset = 1'b0;
        @(negedge clk); tests++;
        if (outs !== O_RST) begin fails++; $display("FAIL mid_stall_reset_outputs: got %b want %b", outs, O_RST); end
        next_cycle();
        reset = 1'b1;
        @(negedge clk); tests++;
        if (outs !== O_RUN) begin fails++; $display("FAIL mid_stall_release_run: got %b want %b", outs, O_RUN); end
`ifdef HAZARD_PERF_EN
        tests++;
        if (stall_cycles !== '0 || flush_count !== '0) begin
            fails++; $display("FAIL perf_after_reset: stall=%0d flush=%0d want 0 0", stall_cycles, flush_count);
        end
        next_cycle();
        br_taken = 1'b1;
        next_cycle();
        id_ex_rd = 5'd2; id_ex_mem_read = 1'b1; if_id_rn = 5'd2;
        next_cycle();
        dmem_busy = 1'b1; br_taken = 1'b1;
        next_cycle();
        @(negedge clk); tests++;
        if (stall_cycles !== CNT_W'(1) || flush_count !== CNT_W'(1)) begin
            fails++; $display("FAIL perf_counts: stall=%0d flush=%0d want 1 1", stall_cycles, flush_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_cbz_after_load();
        test_cbz_after_alu();
        test_flush();
        test_dmem_busy();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
